detector_flancos_multicanal: RTL and testbench
==============================================

// Module: detector_flancos_multicanal
// PURPOSE
//  N-channel edge detector with trigger holdoff, for oscilloscope trigger/event logic.
//  Per channel: optional input synchroniser, rise/fall/both/off select, one-cycle detect pulse,
//  holdoff window, sticky flag, saturating event counter.
//  Sits between debounced/synchronised inputs and the trigger controller / capture FSM.
// PARAMETERS
//  N_CH         4   number of channels (1..16)
//  SYNC_STAGES  2   input synchroniser flops per channel (0..4; 0 = input already synchronous)
//  HOLDOFF_W    8   width of holdoff count
//  CNT_W        16  width of each per-channel event counter
// PORTS
//  clk            in   1            single clock, all logic on posedge
//  reset          in   1            asynchronous, ACTIVE-LOW reset
//  entrada        in   N_CH         channel inputs
//  modo           in   2*N_CH       per-channel mode, ch i = modo[2i+1:2i]
//  holdoff        in   HOLDOFF_W    holdoff cycles after a detection (shared by all channels)
//  clear_flags    in   1            one-cycle pulse, clears all sticky flags
//  clear_conteo   in   1            one-cycle pulse, zeroes all counters
//  deteccion      out  N_CH         one-cycle detect pulse per channel (registered)
//  bandera        out  N_CH         sticky detect flag per channel
//  any_deteccion  out  1            OR of deteccion (registered, same cycle as deteccion)
//  conteo         out  N_CH*CNT_W   saturating detect counts, ch i = [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  Reset (reset=0, async): sync chain, prev sample, deteccion, bandera, any_deteccion,
//   conteo, holdoff counters all 0; every channel in ARMADO.
//  Edge term: s = synchroniser output, p = s delayed 1 cycle (reset 0).
//   modo 00 OFF: none; 01 RISE: s&~p; 10 FALL: ~s&p; 11 BOTH: s^p.
//   Input high at reset release => RISE seen (p resets to 0).
//  Latency: input first sampled at posedge k -> deteccion high for exactly the cycle
//   after posedge k+SYNC_STAGES.
//  Per-channel FSM, 2 states:
//   ARMADO: edge term=1 -> deteccion=1 next cycle; if holdoff!=0 load cnt=holdoff, go ESPERA;
//     if holdoff==0 stay ARMADO (back-to-back detections allowed).
//   ESPERA: edge terms ignored (no pulse, no flag, no count); cnt decrements per cycle;
//     cnt==1 -> ARMADO. Detection at posedge j blocks edge terms at posedges j+1..j+H,
//     edge at j+H+1 detected.
//   holdoff sampled only on load; changes during ESPERA do not affect the running window.
//   modo==00 in ESPERA -> ARMADO next cycle, cnt=0.
//  Mode changes take effect on the next posedge; no spurious pulse from a mode change alone
//   (edge term uses s/p only).
//  bandera[i]: set on deteccion[i]; cleared by clear_flags; same cycle set+clear -> stays 1.
//  conteo[i]: +1 per detection, saturates at 2^CNT_W-1; clear_conteo zeroes;
//   same cycle clear+detect -> 1.
//  Reset mid-holdoff: immediate return to ARMADO, all state cleared, no pulse emitted.
//  Channels independent; simultaneous detections on several channels all reported same cycle.
// STRUCTURE
//  Package detector_flancos_pkg: MODO_OFF/RISE/FALL/BOTH (2'b00..2'b11), state encoding
//   ST_ARMADO/ST_ESPERA.
//  Sub-module detector_flancos_canal: one channel (sync chain, edge select, FSM,
//   holdoff cnt, flag, counter); top instantiates N_CH via generate, ORs any_deteccion.
// TESTING
//  1. N_CH=4,SYNC=2,modo=RISE,holdoff=0: ch0 0->1 sampled at posedge 10 -> deteccion[0] high
//     only in cycle after posedge 12; bandera[0]=1, conteo0=1.
//  2. modo=FALL/BOTH: 1-cycle-wide high pulse on ch1 -> FALL: one pulse on 1->0;
//     BOTH: two pulses 1 cycle apart; conteo1=2.
//  3. holdoff=5, ch2 toggling every cycle, BOTH: detections 6 cycles apart; pulses inside
//     window absent, conteo counts only those detected.
//  4. CNT_W=4: 20 rising edges on ch3 -> conteo3 stops at 15; clear_conteo on same cycle
//     as a detection -> conteo3=1.
//  5. clear_flags coincident with new deteccion[0] -> bandera[0] stays 1; next clear -> 0.
//  6. reset=0 asserted during ESPERA (holdoff=200) -> all outputs 0 asynchronously;
//     after release, entrada held high -> one RISE detect at SYNC_STAGES latency.

Source files
------------

// File: rtl/detector_flancos_pkg.sv
// Shared mode and state encodings for the multichannel edge detector.
package detector_flancos_pkg;

  localparam int unsigned MODO_W = 2;

  typedef enum logic [MODO_W-1:0] {
    MODO_OFF  = 2'b00,
    MODO_RISE = 2'b01,
    MODO_FALL = 2'b10,
    MODO_BOTH = 2'b11
  } modo_e;

  typedef enum logic {
    ST_ARMADO = 1'b0,
    ST_ESPERA = 1'b1
  } estado_e;

endpackage

// File: rtl/detector_flancos_canal.sv
// One edge-detect channel: synchroniser, edge select, holdoff FSM, sticky flag
// and saturating event counter.
module detector_flancos_canal
  import detector_flancos_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF_W   = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entrada,
  input  logic [MODO_W-1:0]    modo,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 clear_flags,
  input  logic                 clear_conteo,
  output logic                 disparo_c,
  output logic                 deteccion,
  output logic                 bandera,
  output logic [CNT_W-1:0]     conteo
);

  logic                 s_c;
  logic                 p_q;
  logic                 flanco_c;
  estado_e              estado_q, estado_d;
  logic [HOLDOFF_W-1:0] cnt_q, cnt_d;

  if (SYNC_STAGES == 0) begin : g_sync0
    assign s_c = entrada;
  end else if (SYNC_STAGES == 1) begin : g_sync1
    logic sync_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= 1'b0;
      else        sync_q <= entrada;
    end
    assign s_c = sync_q;
  end else begin : g_syncn
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], entrada};
    end
    assign s_c = sync_q[SYNC_STAGES-1];
  end

  // Previous synchronised sample; resets low so a high input at release reads as a rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) p_q <= 1'b0;
    else        p_q <= s_c;
  end

  always_comb begin
    flanco_c = 1'b0;
    case (modo_e'(modo))
      MODO_RISE: flanco_c = s_c & ~p_q;
      MODO_FALL: flanco_c = ~s_c & p_q;
      MODO_BOTH: flanco_c = s_c ^ p_q;
      default:   flanco_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= ST_ARMADO;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  // Holdoff is latched only on detection; a zero holdoff keeps the channel armed.
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    disparo_c = 1'b0;
    case (estado_q)
      ST_ARMADO: begin
        if (flanco_c) begin
          disparo_c = 1'b1;
          if (holdoff != '0) begin
            estado_d = ST_ESPERA;
            cnt_d    = holdoff;
          end
        end
      end
      ST_ESPERA: begin
        if (modo_e'(modo) == MODO_OFF || cnt_q == HOLDOFF_W'(1)) begin
          estado_d = ST_ARMADO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - HOLDOFF_W'(1);
        end
      end
      default: begin
        estado_d = ST_ARMADO;
        cnt_d    = '0;
      end
    endcase
  end

  // Set beats clear on the flag; clear plus detect on the counter leaves one event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deteccion <= 1'b0;
      bandera   <= 1'b0;
      conteo    <= '0;
    end else begin
      deteccion <= disparo_c;
      bandera   <= disparo_c | (bandera & ~clear_flags);
      if (clear_conteo)                 conteo <= CNT_W'(disparo_c);
      else if (disparo_c && conteo != '1) conteo <= conteo + CNT_W'(1);
    end
  end

endmodule

// File: rtl/detector_flancos_multicanal.sv
// N-channel edge detector with shared trigger holdoff; one channel instance per input.
module detector_flancos_multicanal
  import detector_flancos_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF_W   = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         entrada,
  input  logic [MODO_W*N_CH-1:0]  modo,
  input  logic [HOLDOFF_W-1:0]    holdoff,
  input  logic                    clear_flags,
  input  logic                    clear_conteo,
  output logic [N_CH-1:0]         deteccion,
  output logic [N_CH-1:0]         bandera,
  output logic                    any_deteccion,
  output logic [N_CH*CNT_W-1:0]   conteo
);

  logic [N_CH-1:0] disparo_c;

  for (genvar i = 0; i < N_CH; i++) begin : g_canal
    detector_flancos_canal #(
      .SYNC_STAGES (SYNC_STAGES),
      .HOLDOFF_W   (HOLDOFF_W),
      .CNT_W       (CNT_W)
    ) u_canal (
      .clk          (clk),
      .reset        (reset),
      .entrada      (entrada[i]),
      .modo         (modo[MODO_W*i +: MODO_W]),
      .holdoff      (holdoff),
      .clear_flags  (clear_flags),
      .clear_conteo (clear_conteo),
      .disparo_c    (disparo_c[i]),
      .deteccion    (deteccion[i]),
      .bandera      (bandera[i]),
      .conteo       (conteo[i*CNT_W +: CNT_W])
    );
  end

  // Registered from the same detect terms so it aligns with deteccion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) any_deteccion <= 1'b0;
    else        any_deteccion <= |disparo_c;
  end

endmodule

// File: tb/tb_detector_flancos_multicanal.sv
// Self-checking bench: a behavioural model queues expected outputs each clock,
// scenario tasks pop and compare them plus targeted spot checks.
module tb_detector_flancos_multicanal;

  localparam int unsigned N_CH = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HW   = 8;
  localparam int unsigned CW   = 4;

  logic                 clk          = 1'b0;
  logic                 reset        = 1'b0;
  logic [N_CH-1:0]      entrada      = '0;
  logic [2*N_CH-1:0]    modo         = '0;
  logic [HW-1:0]        holdoff      = '0;
  logic                 clear_flags  = 1'b0;
  logic                 clear_conteo = 1'b0;
  logic [N_CH-1:0]      deteccion;
  logic [N_CH-1:0]      bandera;
  logic                 any_deteccion;
  logic [N_CH*CW-1:0]   conteo;

  int n_cmp = 0;
  int n_bad = 0;

  detector_flancos_multicanal #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC), .HOLDOFF_W(HW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .entrada(entrada), .modo(modo), .holdoff(holdoff),
    .clear_flags(clear_flags), .clear_conteo(clear_conteo), .deteccion(deteccion),
    .bandera(bandera), .any_deteccion(any_deteccion), .conteo(conteo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0]    det;
    logic [N_CH-1:0]    band;
    logic               any;
    logic [N_CH*CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  bit [SYNC-1:0] m_sh   [N_CH];
  bit            m_p    [N_CH];
  int            m_hold [N_CH];
  bit            m_band [N_CH];
  int            m_cnt  [N_CH];

  function automatic bit edge_f(input logic [1:0] m, input bit s, input bit p);
    case (m)
      2'b01:   return s && !p;
      2'b10:   return !s && p;
      2'b11:   return s != p;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: m_hold counts remaining blocked clocks after a detection.
  always @(posedge clk or negedge reset) begin : model
    exp_t e;
    bit s, fire;
    if (!reset) begin
      for (int c = 0; c < N_CH; c++) begin
        m_sh[c] = '0; m_p[c] = 0; m_hold[c] = 0; m_band[c] = 0; m_cnt[c] = 0;
      end
      exp_q.delete();
    end else begin
      e = '0;
      for (int c = 0; c < N_CH; c++) begin
        s = m_sh[c][SYNC-1];
        fire = 1'b0;
        if (m_hold[c] > 0) begin
          if (modo[2*c +: 2] == 2'b00) m_hold[c] = 0;
          else                         m_hold[c]--;
        end else if (edge_f(modo[2*c +: 2], s, m_p[c])) begin
          fire = 1'b1;
          m_hold[c] = int'(holdoff);
        end
        m_p[c]  = s;
        m_sh[c] = {m_sh[c][SYNC-2:0], entrada[c]};
        m_band[c] = fire | (m_band[c] & !clear_flags);
        if (clear_conteo)                          m_cnt[c] = fire ? 1 : 0;
        else if (fire && m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
        e.det[c]            = fire;
        e.band[c]           = m_band[c];
        e.cnt[c*CW +: CW]   = CW'(m_cnt[c]);
        e.any               = e.any | fire;
      end
      exp_q.push_back(e);
    end
  end

  // Advance one clock and return the queued expectation with the observed outputs.
  task automatic advance(output exp_t e, output exp_t got, output bit v);
    @(negedge clk);
    v   = (exp_q.size() > 0);
    e   = v ? exp_q.pop_front() : '0;
    got = exp_t'({deteccion, bandera, any_deteccion, conteo});
  endtask

  task automatic test_reset();
    reset = 1'b0; entrada = '0; modo = '0; holdoff = '0;
    clear_flags = 1'b0; clear_conteo = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({deteccion, bandera, any_deteccion, conteo} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected 0", {deteccion, bandera, any_deteccion, conteo});
    end
    reset = 1'b1;
  endtask

  task automatic test_rise_latency();
    exp_t e, got; bit v; int first, n;
    modo = 8'b01_01_01_01; holdoff = '0; first = -1; n = 0;
    for (int i = 0; i < 2; i++) begin
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL rise_idle cyc%0d: got %h expected %h", i, got, e); end
    end
    entrada[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL rise cyc%0d: got %h expected %h", i, got, e); end
      if (deteccion[0]) begin n++; if (first < 0) first = i; end
    end
    n_cmp++;
    if (first != 3 || n != 1) begin
      n_bad++; $display("FAIL rise_latency: first=%0d count=%0d expected first=3 count=1", first, n);
    end
    n_cmp++;
    if (bandera[0] !== 1'b1 || conteo[0 +: CW] !== 4'd1) begin
      n_bad++; $display("FAIL rise_flag_count: bandera0=%b conteo0=%0d expected 1 and 1", bandera[0], conteo[0 +: CW]);
    end
  endtask

  task automatic test_fall_both();
    exp_t e, got; bit v; int first, second, n;
    modo[3:2] = 2'b10; first = -1; n = 0;
    for (int i = 0; i < 2; i++) begin
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL fall_idle cyc%0d: got %h expected %h", i, got, e); end
    end
    entrada[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL fall cyc%0d: got %h expected %h", i, got, e); end
      if (i == 1) entrada[1] = 1'b0;
      if (deteccion[1]) begin n++; if (first < 0) first = i; end
    end
    n_cmp++;
    if (first != 4 || n != 1) begin
      n_bad++; $display("FAIL fall_pulse: first=%0d count=%0d expected first=4 count=1", first, n);
    end
    clear_conteo = 1'b1;
    advance(e, got, v); n_cmp++;
    if (!v || got !== e) begin n_bad++; $display("FAIL both_clear: got %h expected %h", got, e); end
    clear_conteo = 1'b0;
    modo[3:2] = 2'b11; first = -1; second = -1; n = 0;
    advance(e, got, v); n_cmp++;
    if (!v || got !== e) begin n_bad++; $display("FAIL both_mode: got %h expected %h", got, e); end
    entrada[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL both cyc%0d: got %h expected %h", i, got, e); end
      if (i == 1) entrada[1] = 1'b0;
      if (deteccion[1]) begin
        n++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    n_cmp++;
    if (first != 3 || second != 4 || n != 2 || conteo[CW +: CW] !== 4'd2) begin
      n_bad++;
      $display("FAIL both_pulses: at %0d,%0d count=%0d conteo1=%0d expected 3,4 count=2 conteo1=2",
               first, second, n, conteo[CW +: CW]);
    end
  endtask

  task automatic test_holdoff();
    exp_t e, got; bit v; int first, last, n, bad_gap;
    holdoff = 8'd5; modo[5:4] = 2'b11; first = -1; last = -1; n = 0; bad_gap = 0;
    advance(e, got, v); n_cmp++;
    if (!v || got !== e) begin n_bad++; $display("FAIL hold_idle: got %h expected %h", got, e); end
    for (int i = 1; i <= 32; i++) begin
      if (i <= 24) entrada[2] = ~entrada[2];
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL hold cyc%0d: got %h expected %h", i, got, e); end
      if (deteccion[2]) begin
        n++;
        if (first < 0) first = i;
        else if (i - last != 6) bad_gap++;
        last = i;
      end
    end
    n_cmp++;
    if (first != 3 || bad_gap != 0 || n != 4 || conteo[2*CW +: CW] !== 4'd4) begin
      n_bad++;
      $display("FAIL hold_window: first=%0d bad_gaps=%0d count=%0d conteo2=%0d expected 3 0 4 4",
               first, bad_gap, n, conteo[2*CW +: CW]);
    end
    holdoff = '0; modo[5:4] = 2'b00;
  endtask

  task automatic test_saturation();
    exp_t e, got; bit v; int n;
    n = 0;
    for (int i = 0; i < 44; i++) begin
      entrada[3] = (i < 40) && (i % 2 == 0);
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL sat cyc%0d: got %h expected %h", i, got, e); end
      if (deteccion[3]) n++;
    end
    n_cmp++;
    if (n != 20 || conteo[3*CW +: CW] !== 4'd15) begin
      n_bad++; $display("FAIL sat_count: pulses=%0d conteo3=%0d expected 20 and 15", n, conteo[3*CW +: CW]);
    end
    entrada[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) clear_conteo = 1'b1;
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL sat_clr cyc%0d: got %h expected %h", i, got, e); end
    end
    clear_conteo = 1'b0;
    n_cmp++;
    if (deteccion[3] !== 1'b1 || conteo[3*CW +: CW] !== 4'd1) begin
      n_bad++; $display("FAIL clear_with_detect: det3=%b conteo3=%0d expected 1 and 1", deteccion[3], conteo[3*CW +: CW]);
    end
  endtask

  task automatic test_flag_clear();
    exp_t e, got; bit v;
    entrada[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL flag_idle cyc%0d: got %h expected %h", i, got, e); end
    end
    entrada[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) clear_flags = 1'b1;
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL flag cyc%0d: got %h expected %h", i, got, e); end
    end
    clear_flags = 1'b0;
    n_cmp++;
    if (deteccion[0] !== 1'b1 || bandera[0] !== 1'b1) begin
      n_bad++; $display("FAIL flag_set_wins: det0=%b bandera0=%b expected 1 and 1", deteccion[0], bandera[0]);
    end
    clear_flags = 1'b1;
    advance(e, got, v); n_cmp++;
    if (!v || got !== e) begin n_bad++; $display("FAIL flag_clr: got %h expected %h", got, e); end
    clear_flags = 1'b0;
    n_cmp++;
    if (bandera[0] !== 1'b0) begin n_bad++; $display("FAIL flag_cleared: bandera0=%b expected 0", bandera[0]); end
  endtask

  task automatic test_simultaneous();
    exp_t e, got; bit v;
    modo = 8'b01_01_01_01; entrada = '0;
    for (int i = 0; i < 3; i++) begin
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL simul_idle cyc%0d: got %h expected %h", i, got, e); end
    end
    entrada = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL simul cyc%0d: got %h expected %h", i, got, e); end
      if (i == 3) begin
        n_cmp++;
        if (deteccion !== 4'hF || any_deteccion !== 1'b1) begin
          n_bad++; $display("FAIL simul_all: det=%b any=%b expected 1111 and 1", deteccion, any_deteccion);
        end
      end
    end
  endtask

  task automatic test_reset_holdoff();
    exp_t e, got; bit v; int first, n;
    modo = 8'b00_00_00_01; entrada = '0; holdoff = 8'd200; first = -1; n = 0;
    for (int i = 0; i < 3; i++) begin
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL rh_idle cyc%0d: got %h expected %h", i, got, e); end
    end
    entrada[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL rh_arm cyc%0d: got %h expected %h", i, got, e); end
      if (i == 3) begin
        n_cmp++;
        if (deteccion[0] !== 1'b1) begin n_bad++; $display("FAIL rh_detect: det0=%b expected 1", deteccion[0]); end
      end
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({deteccion, bandera, any_deteccion, conteo} !== 25'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %h expected 0", {deteccion, bandera, any_deteccion, conteo});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      advance(e, got, v); n_cmp++;
      if (!v || got !== e) begin n_bad++; $display("FAIL rh_post cyc%0d: got %h expected %h", i, got, e); end
      if (deteccion[0]) begin n++; if (first < 0) first = i; end
    end
    n_cmp++;
    if (first != 3 || n != 1 || bandera[0] !== 1'b1 || conteo[0 +: CW] !== 4'd1) begin
      n_bad++;
      $display("FAIL rh_after_release: first=%0d count=%0d bandera0=%b conteo0=%0d expected 3 1 1 1",
               first, n, bandera[0], conteo[0 +: CW]);
    end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_fall_both();
    test_holdoff();
    test_saturation();
    test_flag_clear();
    test_simultaneous();
    test_reset_holdoff();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
